cost_epoch_monitor: RTL

- Reader/controller on the far side of the cost accumulator. It gates the accumulator enable per training sample, counts samples per epoch, and clears the accumulator between epochs.
- At each epoch end it reads the accumulated cost, averages it over the epoch, and compares the average against a convergence threshold.
- It signals epoch completion, convergence, or epoch-limit exhaustion to the training sequencer.

---
 rtl/cost_epoch_monitor.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/cost_epoch_monitor.sv
// Epoch controller on the far side of the cost accumulator.
// It gates the accumulator enable, counts samples per epoch, and clears the
// accumulator between epochs. At each epoch end it averages the accumulated
// cost and compares the average against the convergence threshold.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | no run since reset; waits for i_start
// CLEAR  | one-cycle accumulator clear, sample counter reset
// RUN    | accepting samples until 2^LOG2_SAMPLES have been taken
// SETTLE | one cycle for the accumulator register to absorb last sample
// EVAL   | average cost, bump epoch count, decide converge/limit/next
// DONE   | run finished; results held until the next i_start
module cost_epoch_monitor #(
  parameter int WIDTH        = 32,
  parameter int FRAC         = 24,
  parameter int LOG2_SAMPLES = 2,
  parameter int EPOCH_W      = 16,
  parameter int MAX_EPOCH    = 1000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_start,
  input  logic               i_sample_valid,
  output logic               o_sample_ready,
  input  logic [WIDTH-1:0]   i_cost,
  input  logic [WIDTH-1:0]   i_threshold,
  output logic               o_acc_en,
  output logic               o_acc_clr,
  output logic [WIDTH-1:0]   o_cost_avg,
  output logic [EPOCH_W-1:0] o_epoch_cnt,
  output logic               o_epoch_done,
  output logic               o_converged,
  output logic               o_busy
);

  // Reject parameter sets the datapath cannot represent.
  if (FRAC < 0 || FRAC >= WIDTH || LOG2_SAMPLES < 1 || LOG2_SAMPLES >= WIDTH ||
      MAX_EPOCH < 1 || MAX_EPOCH >= (1 << EPOCH_W)) begin : g_bad_param
    $error("cost_epoch_monitor: parameter out of range");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_SETTLE,
    S_EVAL,
    S_DONE
  } state_t;

  localparam logic [EPOCH_W-1:0]      MAX_EPOCH_W = EPOCH_W'(MAX_EPOCH);
  localparam logic [LOG2_SAMPLES-1:0] LAST_SMP    = '1;

  state_t                  r_state;
  logic [LOG2_SAMPLES-1:0] r_smp_cnt;
  logic                    r_ready;
  logic                    r_acc_clr;
  logic                    r_epoch_done;
  logic                    r_converged;
  logic                    r_busy;
  logic [WIDTH-1:0]        r_cost_avg;
  logic [EPOCH_W-1:0]      r_epoch_cnt;

  logic                    w_acc_en;
  logic [WIDTH-1:0]        w_avg;
  logic                    w_conv;
  logic [EPOCH_W-1:0]      w_epoch_nxt;

  assign w_acc_en    = i_sample_valid & r_ready;
  // Arithmetic shift keeps the sign and rounds toward -inf.
  assign w_avg       = WIDTH'($signed(i_cost) >>> LOG2_SAMPLES);
  assign w_conv      = $signed(w_avg) <= $signed(i_threshold);
  assign w_epoch_nxt = r_epoch_cnt + 1'b1;

  // Sequencing FSM; every status output is a register updated with the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_smp_cnt    <= '0;
      r_ready      <= 1'b0;
      r_acc_clr    <= 1'b0;
      r_epoch_done <= 1'b0;
      r_converged  <= 1'b0;
      r_busy       <= 1'b0;
      r_cost_avg   <= '0;
      r_epoch_cnt  <= '0;
    end else begin
      r_acc_clr    <= 1'b0;
      r_epoch_done <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (i_start) begin
            r_state     <= S_CLEAR;
            r_epoch_cnt <= '0;
            r_converged <= 1'b0;
            r_acc_clr   <= 1'b1;
            r_busy      <= 1'b1;
          end
        end
        S_CLEAR: begin
          r_smp_cnt <= '0;
          r_ready   <= 1'b1;
          r_state   <= S_RUN;
        end
        S_RUN: begin
          if (w_acc_en) begin
            r_smp_cnt <= r_smp_cnt + 1'b1;
            if (r_smp_cnt == LAST_SMP) begin
              r_ready <= 1'b0;
              r_state <= S_SETTLE;
            end
          end
        end
        S_SETTLE: begin
          r_state <= S_EVAL;
        end
        S_EVAL: begin
          r_cost_avg   <= w_avg;
          r_epoch_cnt  <= w_epoch_nxt;
          r_epoch_done <= 1'b1;
          if (w_conv) begin
            r_converged <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= S_DONE;
          end else if (w_epoch_nxt == MAX_EPOCH_W) begin
            r_busy  <= 1'b0;
            r_state <= S_DONE;
          end else begin
            r_acc_clr <= 1'b1;
            r_state   <= S_CLEAR;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_sample_ready = r_ready;
  assign o_acc_en       = w_acc_en;
  assign o_acc_clr      = r_acc_clr;
  assign o_cost_avg     = r_cost_avg;
  assign o_epoch_cnt    = r_epoch_cnt;
  assign o_epoch_done   = r_epoch_done;
  assign o_converged    = r_converged;
  assign o_busy         = r_busy;

endmodule
